// File: rtl/nand_flash_responder.sv
// NAND flash target model: decodes CLE/ALE/WEN/REN strobe cycles and serves page reads/programs.
// Optional read-status command (0x70) enabled by defining NAND_RESP_STATUS_EN.
module nand_flash_responder #(
  parameter int PAGE_AW = 9,
  parameter int COL_AW  = 9,
  parameter int T_R     = 25,
  parameter int T_PROG  = 200
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire  [7:0] F_IO,
  input  logic       F_CLE,
  input  logic       F_ALE,
  input  logic       F_WEN,
  input  logic       F_REN,
  output logic       F_RB
);

  localparam int PAGE_BYTES = 1 << COL_AW;
  localparam int CNT_W      = $clog2(PAGE_BYTES + T_PROG + T_R + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RADDR  = 3'd1;
  localparam logic [2:0] S_RBUSY  = 3'd2;
  localparam logic [2:0] S_RDATA  = 3'd3;
  localparam logic [2:0] S_PADDR  = 3'd4;
  localparam logic [2:0] S_PDATA  = 3'd5;
  localparam logic [2:0] S_PBUSY  = 3'd6;
  localparam logic [2:0] S_STATUS = 3'd7;

  logic [2:0]            state_q, state_d;
  logic [COL_AW:0]       col_q, col_d;
  logic [PAGE_AW-1:0]    page_q, page_d;
  logic [1:0]            addr_cnt_q, addr_cnt_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PAGE_BYTES-1:0] dirty_q, dirty_d;
  logic                  wen_q, ren_q, rb_q, rb_d;
  logic                  buf_we, mem_we;
  logic [7:0]            page_buf_q [PAGE_BYTES];
  logic [7:0]            mem_q [1 << (PAGE_AW + COL_AW)];

  logic                  busy, wr_ev, rd_ev, cmd_ev, addr_ev, data_ev;
  logic [COL_AW-1:0]     col_idx, copy_idx;
  logic [7:0]            rd_byte, io_out;
  logic                  io_drive;

  assign col_idx  = col_q[COL_AW-1:0];
  assign copy_idx = cnt_q[COL_AW-1:0];
  assign busy     = (state_q == S_RBUSY) || (state_q == S_PBUSY);
  // A strobe overlapping the other strobe is a protocol error and produces no event.
  assign wr_ev    = !wen_q && F_WEN && ren_q && !busy;
  assign rd_ev    = !ren_q && F_REN && wen_q && !busy;
  assign cmd_ev   = wr_ev && F_CLE && !F_ALE;
  assign addr_ev  = wr_ev && F_ALE && !F_CLE;
  assign data_ev  = wr_ev && !F_CLE && !F_ALE;
  assign rd_byte  = mem_q[{page_q, col_idx}];

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    page_d     = page_q;
    addr_cnt_d = addr_cnt_q;
    cnt_d      = cnt_q;
    dirty_d    = dirty_q;
    buf_we     = 1'b0;
    mem_we     = 1'b0;
    case (state_q)
      S_RBUSY: begin
        if (cnt_q == CNT_W'(T_R - 1)) begin
          state_d = S_RDATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PBUSY: begin
        // Copy phase first, then the remaining T_PROG cycles just hold busy.
        if (cnt_q < CNT_W'(PAGE_BYTES)) mem_we = dirty_q[copy_idx];
        else mem_we = 1'b0;
        if (cnt_q == CNT_W'(PAGE_BYTES + T_PROG - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: cnt_d = cnt_q;
    endcase

    if (cmd_ev) begin
      case (F_IO)
        8'h00, 8'h01: begin
          col_d      = {1'b0, F_IO[0], col_q[COL_AW-2:0]};
          addr_cnt_d = 2'd0;
          state_d    = S_RADDR;
        end
        8'h80: begin
          col_d      = {1'b0, 1'b0, col_q[COL_AW-2:0]};
          addr_cnt_d = 2'd0;
          dirty_d    = '0;
          state_d    = S_PADDR;
        end
        8'h10: begin
          if (state_q == S_PDATA) begin
            state_d = S_PBUSY;
            cnt_d   = '0;
          end else if (state_q == S_STATUS) begin
            state_d = S_IDLE;
          end else begin
            state_d = state_q;
          end
        end
        8'hFF: state_d = S_IDLE;
`ifdef NAND_RESP_STATUS_EN
        8'h70: state_d = S_STATUS;
`endif
        default: begin
          if (state_q == S_STATUS) state_d = S_IDLE;
          else state_d = state_q;
        end
      endcase
    end else if (addr_ev) begin
      if ((state_q == S_RADDR) || (state_q == S_PADDR)) begin
        case (addr_cnt_q)
          2'd0: begin
            col_d      = {1'b0, col_q[COL_AW-1:8], F_IO};
            addr_cnt_d = 2'd1;
          end
          2'd1: begin
            page_d     = {page_q[PAGE_AW-1:8], F_IO};
            addr_cnt_d = 2'd2;
          end
          default: begin
            page_d[8]  = F_IO[0];
            addr_cnt_d = 2'd0;
            cnt_d      = '0;
            state_d    = (state_q == S_RADDR) ? S_RBUSY : S_PDATA;
          end
        endcase
      end else begin
        addr_cnt_d = addr_cnt_q;
      end
    end else if (data_ev && (state_q == S_PDATA) && !col_q[COL_AW]) begin
      // Column saturates past the page end so overflow bytes are dropped, not wrapped.
      buf_we           = 1'b1;
      dirty_d[col_idx] = 1'b1;
      col_d            = col_q + (COL_AW + 1)'(1);
    end else if (rd_ev && (state_q == S_RDATA)) begin
      col_d = {1'b0, col_idx + COL_AW'(1)};
    end else begin
      col_d = col_q;
    end

    rb_d = !((state_d == S_RBUSY) || (state_d == S_PBUSY));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      page_q     <= '0;
      addr_cnt_q <= 2'd0;
      cnt_q      <= '0;
      dirty_q    <= '0;
      wen_q      <= 1'b1;
      ren_q      <= 1'b1;
      rb_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      page_q     <= page_d;
      addr_cnt_q <= addr_cnt_d;
      cnt_q      <= cnt_d;
      dirty_q    <= dirty_d;
      wen_q      <= F_WEN;
      ren_q      <= F_REN;
      rb_q       <= rb_d;
    end
  end

  // Storage is never reset; a reset mid-copy leaves the partially committed page.
  always_ff @(posedge clk) begin
    if (rst && buf_we) page_buf_q[col_idx] <= F_IO;
    if (rst && mem_we) mem_q[{page_q, copy_idx}] <= page_buf_q[copy_idx];
  end

`ifdef NAND_RESP_STATUS_EN
  assign io_drive = !F_REN && ((state_q == S_RDATA) || (state_q == S_STATUS));
  assign io_out   = (state_q == S_STATUS) ? {1'b1, rb_q, 6'b000000} : rd_byte;
`else
  assign io_drive = !F_REN && (state_q == S_RDATA);
  assign io_out   = rd_byte;
`endif

  assign F_IO = io_drive ? io_out : 8'hzz;
  assign F_RB = rb_q;

endmodule

// File: tb/tb_nand_flash_responder.sv
// Self-checking bench for nand_flash_responder: directed sequence with random page/data,
// checked against an associative-array page model. F_IO is pulled up, so an undriven bus reads 0xFF.
module tb_nand_flash_responder;

  localparam int T_R    = 25;
  localparam int T_PROG = 200;
  localparam int PB     = 512;

  logic       clk = 1'b0;
  logic       rst, cle, ale, wen, ren, tb_oe;
  logic [7:0] tb_io;
  logic       rb;
  tri1  [7:0] f_io;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] model_mem [int];

  assign f_io = tb_oe ? tb_io : 8'hzz;

  always #5 clk = ~clk;

  nand_flash_responder #(
    .PAGE_AW(9), .COL_AW(9), .T_R(T_R), .T_PROG(T_PROG)
  ) dut (
    .clk(clk), .rst(rst), .F_IO(f_io), .F_CLE(cle), .F_ALE(ale),
    .F_WEN(wen), .F_REN(ren), .F_RB(rb)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic c, input logic a, input logic [7:0] d);
    @(negedge clk);
    cle = c; ale = a; tb_io = d; tb_oe = 1'b1; wen = 1'b0;
    @(negedge clk);
    wen = 1'b1;
    @(negedge clk);
    tb_oe = 1'b0; cle = 1'b0; ale = 1'b0;
  endtask

  task automatic rd(output logic [7:0] d);
    @(negedge clk);
    ren = 1'b0;
    @(posedge clk);
    #1 d = f_io;
    @(negedge clk);
    ren = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_addr(input int page, input int col_lo);
    logic [8:0] p;
    logic [7:0] c;
    p = page[8:0];
    c = col_lo[7:0];
    wr(1'b0, 1'b1, c);
    wr(1'b0, 1'b1, p[7:0]);
    wr(1'b0, 1'b1, {7'b0000000, p[8]});
  endtask

  // Counts busy cycles from the current negedge; optionally strobes command 0x00 mid-busy.
  task automatic busy_len(input int inject_at, output int n);
    n = 0;
    while (rb === 1'b0 && n < 2000) begin
      if (n == inject_at) begin
        cle = 1'b1; tb_io = 8'h00; tb_oe = 1'b1; wen = 1'b0;
      end else if (n == inject_at + 1) begin
        wen = 1'b1;
      end else if (n == inject_at + 2) begin
        tb_oe = 1'b0; cle = 1'b0;
      end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic prog(input int page, input int col0, input logic [7:0] data[$],
                      input int inject, input string tag);
    int n;
    wr(1'b1, 1'b0, 8'h80);
    send_addr(page, col0);
    foreach (data[i]) wr(1'b0, 1'b0, data[i]);
    wr(1'b1, 1'b0, 8'h10);
    busy_len(inject, n);
    chk_int({tag, "_busy"}, n, PB + T_PROG);
    foreach (data[i]) if (col0 + i < PB) model_mem[page * PB + col0 + i] = data[i];
  endtask

  task automatic rd_check(input logic [7:0] cmd, input int page, input int col_lo,
                          input int nbytes, input string tag);
    int n, start, key;
    logic [7:0] d;
    start = int'(cmd[0]) * 256 + col_lo;
    wr(1'b1, 1'b0, cmd);
    send_addr(page, col_lo);
    busy_len(-1, n);
    chk_int({tag, "_tr"}, n, T_R);
    for (int i = 0; i < nbytes; i++) begin
      key = page * PB + (start + i) % PB;
      rd(d);
      if (model_mem.exists(key)) chk(tag, d, model_mem[key]);
    end
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] q[$];
    int p;

    rst = 1'b0; cle = 1'b0; ale = 1'b0; wen = 1'b1; ren = 1'b1; tb_oe = 1'b0; tb_io = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_rb", {7'b0000000, rb}, 8'h01);
    chk("reset_io", f_io, 8'hff);
    rst = 1'b1;
    rd(d);
    chk("idle_ren_nodrive", d, 8'hff);

    q.delete();
    for (int i = 0; i < PB; i++) q.push_back(8'(i));
    prog(5, 0, q, -1, "prog_p5");
    rd_check(8'h00, 5, 0, PB, "read_p5");
    rd_check(8'h01, 5, 0, 257, "read_p5_hi_wrap");

    // Random page, two bytes beyond the page end must be discarded rather than wrap.
    p = $urandom_range(6, 510);
    q.delete();
    for (int i = 0; i < PB + 2; i++) q.push_back(8'($urandom));
    prog(p, 0, q, -1, "prog_rand");
    rd_check(8'h00, p, $urandom_range(0, 255), PB + 8, "read_rand");

    q.delete();
    for (int i = 0; i < PB; i++) q.push_back(8'($urandom));
    prog(511, 0, q, -1, "prog_p1ff_fill");
    q.delete();
    q.push_back(8'hA5); q.push_back(8'h5A); q.push_back(8'hC3); q.push_back(8'h3C);
    prog(511, 0, q, 10, "prog_p1ff_partial");
    rd(d);
    chk("idle_after_prog_nodrive", d, 8'hff);
    rd_check(8'h00, 511, 0, 8, "read_p1ff");

    wr(1'b1, 1'b0, 8'h00);
    send_addr(5, 0);
    repeat (5) @(negedge clk);
    chk("rbusy_low", {7'b0000000, rb}, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_rbusy_rb", {7'b0000000, rb}, 8'h01);
    rst = 1'b1;
    rd(d);
    chk("rst_in_rbusy_nodrive", d, 8'hff);
    rd_check(8'h00, 5, 16, 32, "read_after_rst");

    wr(1'b1, 1'b0, 8'hFF);
    rd(d);
    chk("cmd_ff_idle", d, 8'hff);
    wr(1'b1, 1'b0, 8'h70);
    rd(d);
`ifdef NAND_RESP_STATUS_EN
    chk("status_ready", d, 8'hc0);
    wr(1'b1, 1'b0, 8'hFF);
    rd(d);
    chk("status_left", d, 8'hff);
`else
    chk("status_ignored", d, 8'hff);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
